mem_ctrl_arb: RTL and testbench
===============================

Name: mem_ctrl_arb

Overview:
- Parametrised byte-serial RAM controller and arbiter between the load/store buffer (LSB) and the instruction cache.
- Serves LSB byte/half/word loads and stores, and icache line fills of LINE_BYTES bytes, over a single 8-bit RAM port with 1-cycle read latency.
- Adds valid/ready handshakes, configurable line size, correct RISC-V load extension, IO-store back-pressure and flush-abort of speculative reads.

Parameters:
ADDR_WIDTH, 32, address width
LINE_BYTES, 4, icache fill size in bytes; power of 2, range 4..64
LSB_ID_WIDTH, 4, width of the LSB entry tag

Ports:
clk  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; 0 freezes the block
flush  in  1  misprediction flush
io_buffer_full  in  1  UART buffer full
mem_din  in  8  RAM read data, valid the cycle after the address
mem_dout  out  8  RAM write data
mem_a  out  ADDR_WIDTH  RAM address
mem_wr  out  1  1 = write
lsb_req_valid  in  1  LSB request valid
lsb_req_ready  out  1  controller accepts LSB request
lsb_req_store  in  1  1 = store
lsb_req_funct3  in  3  RISC-V funct3 of the access
lsb_req_addr  in  ADDR_WIDTH  byte address
lsb_req_data  in  32  store data
lsb_req_id  in  LSB_ID_WIDTH  tag
lsb_resp_valid  out  1  one-cycle completion pulse
lsb_resp_store  out  1  completed op was a store
lsb_resp_id  out  LSB_ID_WIDTH  tag of completed op
lsb_resp_data  out  32  extended load data; 0 for stores
ic_req_valid  in  1  fill request
ic_req_ready  out  1  fill accepted
ic_req_addr  in  ADDR_WIDTH  fill address; low log2(LINE_BYTES) bits ignored/forced 0
ic_resp_valid  out  1  one-cycle fill-done pulse
ic_resp_addr  out  ADDR_WIDTH  aligned line address
ic_resp_line  out  LINE_BYTES*8  line data, little-endian (byte k at [8k+7:8k])

Behaviour:
- Clocking/reset: one clock clk; rst_in is synchronous, active-high.
- Reset: state IDLE; every output 0; byte counter 0; all latched request fields 0.
- States:
  - IDLE: ready outputs = 1 only here; mem_a=0, mem_wr=0, mem_dout=0.
  - LSB_RD, LSB_WR, IC_RD: sequencing states.
  - RESP: response pulse.
  - Transition RESP -> IDLE after 1 cycle.
- Arbitration (IDLE, rdy_in=1, flush=0):
  - LSB has priority over icache.
  - ic_req_ready = 1 only when lsb_req_valid = 0.
  - Handshake = valid & ready in the same cycle; request fields latched at that edge.
  - flush=1 in IDLE blocks acceptance that cycle.
- Byte count N:
  - LSB: funct3[1:0] 00 -> 1, 01 -> 2, 10 -> 4.
  - icache: LINE_BYTES.
- Read timing (acceptance at cycle A):
  - Cycles A+1..A+N drive mem_a = base+k, mem_wr=0.
  - mem_din captured at the end of A+2..A+N+1; the capture in cycle A+N+1 happens in RESP-entry logic.
  - Response pulse in cycle A+N+2 (RESP).
  - Busy length N+2 cycles.
- Write timing:
  - Cycles A+1..A+N drive mem_wr=1, mem_a = base+k, mem_dout = data[8k+7:8k].
  - lsb_resp_valid with lsb_resp_store=1 in cycle A+N+1.
- IO stall:
  - Applies to a store whose address has addr[17:16]==2'b11.
  - While io_buffer_full=1: mem_wr=0 and the counter does not advance; resume when it drops.
  - IO loads are never stalled.
- Load extension:
  - 000 -> sign-extend byte; 001 -> sign-extend half; 010 -> word.
  - 100 -> zero-extend byte; 101 -> zero-extend half.
  - Other funct3 values -> word.
- Flush:
  - In LSB_RD, IC_RD, or RESP for a read: abort; next state IDLE; no response pulse; mem_wr=0.
  - In LSB_WR or RESP for a store: ignored (committed store); the store completes and is acknowledged.
- rdy_in=0:
  - State, counter and captured data hold.
  - mem_wr forced 0.
  - No handshake accepted.
  - Response outputs hold their values; the pulse is re-emitted when rdy_in returns.
- Address wrap: base+k computed modulo 2^ADDR_WIDTH.
- Response fields:
  - lsb_resp_* and ic_resp_* hold their last values outside the pulse.
  - Their valid bits are 0 except in RESP.

Test Plan:
- LB from 0x100, RAM[0x100]=0x80, funct3=000, id=5 -> mem_a=0x100 in cycle A+1; resp pulse at A+3 with data=0xFFFFFF80, id=5. Repeat with funct3=100 -> data=0x00000080.
- SW 0x11223344 to 0x200 -> writes 0x44,0x33,0x22,0x11 to 0x200..0x203 in A+1..A+4; resp_store=1 at A+5; readback LW returns 0x11223344.
- LINE_BYTES=16, fill at 0x1008 -> addresses 0x1000..0x100F; ic_resp_addr=0x1000; ic_resp_line[7:0]=RAM[0x1000]; pulse at A+18.
- lsb_req_valid and ic_req_valid asserted together -> LSB accepted first, icache accepted in the cycle after the LSB RESP; no overlap on mem_a.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then one write of the byte; flush asserted mid-stall -> store still completes and is acknowledged.
- Flush during a 4-byte LW at its second byte -> no lsb_resp_valid; IDLE next cycle; an immediate new request is accepted. Reset mid-fill -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_ctrl_arb_if.sv
// mem_ctrl_arb_if: LSB and icache request/response bundle for mem_ctrl_arb
// master: requester side (LSB + icache); slave: the controller.
// lsb_req_* / lsb_resp_*: load/store requests with tag; ic_req_* / ic_resp_*: line fills.
interface mem_ctrl_arb_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_BYTES   = 4,
    parameter int LSB_ID_WIDTH = 4
);
    logic                    lsb_req_valid;
    logic                    lsb_req_ready;
    logic                    lsb_req_store;
    logic [2:0]              lsb_req_funct3;
    logic [ADDR_WIDTH-1:0]   lsb_req_addr;
    logic [31:0]             lsb_req_data;
    logic [LSB_ID_WIDTH-1:0] lsb_req_id;
    logic                    lsb_resp_valid;
    logic                    lsb_resp_store;
    logic [LSB_ID_WIDTH-1:0] lsb_resp_id;
    logic [31:0]             lsb_resp_data;
    logic                    ic_req_valid;
    logic                    ic_req_ready;
    logic [ADDR_WIDTH-1:0]   ic_req_addr;
    logic                    ic_resp_valid;
    logic [ADDR_WIDTH-1:0]   ic_resp_addr;
    logic [LINE_BYTES*8-1:0] ic_resp_line;
    modport master (
        output lsb_req_valid, lsb_req_store, lsb_req_funct3, lsb_req_addr, lsb_req_data, lsb_req_id,
        output ic_req_valid, ic_req_addr,
        input  lsb_req_ready, lsb_resp_valid, lsb_resp_store, lsb_resp_id, lsb_resp_data,
        input  ic_req_ready, ic_resp_valid, ic_resp_addr, ic_resp_line
    );
    modport slave (
        input  lsb_req_valid, lsb_req_store, lsb_req_funct3, lsb_req_addr, lsb_req_data, lsb_req_id,
        input  ic_req_valid, ic_req_addr,
        output lsb_req_ready, lsb_resp_valid, lsb_resp_store, lsb_resp_id, lsb_resp_data,
        output ic_req_ready, ic_resp_valid, ic_resp_addr, ic_resp_line
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: byte-serial RAM controller arbitrating LSB accesses and icache line fills
// clk/rst_in: clock, sync active-high reset; rdy_in: global enable; flush: drop speculative reads
// io_buffer_full: stalls IO stores; mem_*: 8-bit RAM port, 1-cycle read latency
// bus: LSB and icache handshakes (slave side)
module mem_ctrl_arb #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_BYTES   = 4,
    parameter int LSB_ID_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    mem_ctrl_arb_if.slave         bus
);
    localparam int CW = $clog2(LINE_BYTES) + 1;
    localparam int LW = LINE_BYTES * 8;
    localparam int BW = $clog2(LW);
    typedef enum logic [2:0] {IDLE, LSB_RD, LSB_WR, IC_RD, RESP} state_t;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, n_q, n_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d, raddr_q, raddr_d;
    logic [2:0]              f3_q, f3_d;
    logic [31:0]             wdat_q, wdat_d, rdat_q, rdat_d;
    logic [LSB_ID_WIDTH-1:0] id_q, id_d, rid_q, rid_d;
    logic                    st_q, st_d, ic_q, ic_d, rs_q, rs_d;
    logic [LW-1:0]           buf_q, buf_d, rline_q, rline_d;
    logic                    acc_ok, lsb_go, ic_go, rd, stall, resp;
    logic [CW-1:0]           a_off, bidx;
    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f);
        return f == 3'b000 ? {{24{w[7]}}, w[7:0]} :
               f == 3'b001 ? {{16{w[15]}}, w[15:0]} :
               f == 3'b100 ? {24'b0, w[7:0]} :
               f == 3'b101 ? {16'b0, w[15:0]} : w;
    endfunction
    assign acc_ok = state_q == IDLE && rdy_in && !flush && !rst_in;
    assign lsb_go = acc_ok && bus.lsb_req_valid;
    assign ic_go  = acc_ok && !bus.lsb_req_valid && bus.ic_req_valid;
    assign rd     = state_q == LSB_RD || state_q == IC_RD;
    assign stall  = state_q == LSB_WR && base_q[17:16] == 2'b11 && io_buffer_full;
    assign bidx   = cnt_q - 1'b1;
    // While frozen mid-read, re-present the previous byte address so that the
    // RAM output seen on resume is still the byte the counter expects to capture.
    assign a_off  = cnt_q - CW'(rd && !rdy_in && cnt_q != '0);
    assign resp   = state_q == RESP && rdy_in && (st_q || !flush);
    assign mem_a    = (rd && (cnt_q != n_q || !rdy_in)) || state_q == LSB_WR ? base_q + ADDR_WIDTH'(a_off) : '0;
    assign mem_wr   = state_q == LSB_WR && rdy_in && !stall;
    assign mem_dout = state_q == LSB_WR ? wdat_q[{cnt_q[1:0], 3'b000} +: 8] : '0;
    assign bus.lsb_req_ready  = acc_ok;
    assign bus.ic_req_ready   = acc_ok && !bus.lsb_req_valid;
    assign bus.lsb_resp_valid = resp && !ic_q;
    assign bus.ic_resp_valid  = resp && ic_q;
    assign bus.lsb_resp_store = rs_q;
    assign bus.lsb_resp_id    = rid_q;
    assign bus.lsb_resp_data  = rdat_q;
    assign bus.ic_resp_addr   = raddr_q;
    assign bus.ic_resp_line   = rline_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        base_d  = base_q;
        f3_d    = f3_q;
        wdat_d  = wdat_q;
        id_d    = id_q;
        st_d    = st_q;
        ic_d    = ic_q;
        buf_d   = buf_q;
        rs_d    = rs_q;
        rid_d   = rid_q;
        rdat_d  = rdat_q;
        raddr_d = raddr_q;
        rline_d = rline_q;
        if (rdy_in) begin
            if (lsb_go) begin
                state_d = bus.lsb_req_store ? LSB_WR : LSB_RD;
                cnt_d   = '0;
                n_d     = bus.lsb_req_funct3[1:0] == 2'b00 ? CW'(1) : bus.lsb_req_funct3[1:0] == 2'b01 ? CW'(2) : CW'(4);
                base_d  = bus.lsb_req_addr;
                f3_d    = bus.lsb_req_funct3;
                wdat_d  = bus.lsb_req_data;
                id_d    = bus.lsb_req_id;
                st_d    = bus.lsb_req_store;
                ic_d    = 1'b0;
            end else if (ic_go) begin
                state_d = IC_RD;
                cnt_d   = '0;
                n_d     = CW'(LINE_BYTES);
                base_d  = bus.ic_req_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
                st_d    = 1'b0;
                ic_d    = 1'b1;
            end else if (rd) begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    // Byte k arrives while the counter already points at k+1.
                    if (cnt_q != '0) buf_d[BW'({bidx, 3'b000}) +: 8] = mem_din;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == n_q) begin
                        state_d = RESP;
                        cnt_d   = '0;
                        if (ic_q) begin
                            raddr_d = base_q;
                            rline_d = buf_d;
                        end else begin
                            rs_d   = 1'b0;
                            rid_d  = id_q;
                            rdat_d = ext(buf_d[31:0], f3_q);
                        end
                    end
                end
            end else if (state_q == LSB_WR && !stall) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == n_q - 1'b1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    rs_d    = 1'b1;
                    rid_d   = id_q;
                    rdat_d  = '0;
                end
            end else if (state_q == RESP) begin
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            base_q  <= '0;
            f3_q    <= '0;
            wdat_q  <= '0;
            id_q    <= '0;
            st_q    <= 1'b0;
            ic_q    <= 1'b0;
            buf_q   <= '0;
            rs_q    <= 1'b0;
            rid_q   <= '0;
            rdat_q  <= '0;
            raddr_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            base_q  <= base_d;
            f3_q    <= f3_d;
            wdat_q  <= wdat_d;
            id_q    <= id_d;
            st_q    <= st_d;
            ic_q    <= ic_d;
            buf_q   <= buf_d;
            rs_q    <= rs_d;
            rid_q   <= rid_d;
            rdat_q  <= rdat_d;
            raddr_q <= raddr_d;
            rline_q <= rline_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// tb_mem_ctrl_arb: scoreboard bench for mem_ctrl_arb with a 256 KiB byte RAM model
module tb_mem_ctrl_arb;
    localparam int LB = 16;
    localparam int MW = 262144;
    typedef struct {
        bit           ic;
        bit           st;
        logic [3:0]   id;
        logic [127:0] data;
        logic [31:0]  addr;
        int           due;
    } exp_t;
    logic        clk = 0, rst_in, rdy_in, flush, io_full;
    logic [7:0]  mem_din = 0, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  ram [MW];
    logic [7:0]  mdl [MW];
    exp_t        sbq[$];
    exp_t        me;
    int          n_chk = 0, n_fail = 0, cyc = 0, acc, acc2;
    logic [2:0]  lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    mem_ctrl_arb_if #(.ADDR_WIDTH(32), .LINE_BYTES(LB), .LSB_ID_WIDTH(4)) bus ();
    mem_ctrl_arb #(.ADDR_WIDTH(32), .LINE_BYTES(LB), .LSB_ID_WIDTH(4)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .io_buffer_full(io_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [7:0] pat(input int i);
        return i == 32'h100 ? 8'h80 : 8'(i * 7 + (i >> 8) + 3);
    endfunction
    initial begin
        logic [17:0] a;
        logic        w;
        logic [7:0]  d;
        for (int i = 0; i < MW; i++) ram[i] = pat(i);
        forever begin
            @(negedge clk);
            a = mem_a[17:0];
            w = mem_wr;
            d = mem_dout;
            @(posedge clk);
            #1;
            mem_din = ram[a];
            if (w) ram[a] = d;
        end
    end
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] ld_exp(input logic [2:0] f, input logic [31:0] a);
        logic [31:0] w;
        w = {mdl[18'(a + 3)], mdl[18'(a + 2)], mdl[18'(a + 1)], mdl[18'(a)]};
        case (f)
            3'b000: return {{24{w[7]}}, w[7:0]};
            3'b001: return {{16{w[15]}}, w[15:0]};
            3'b100: return {24'b0, w[7:0]};
            3'b101: return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic lsb_op(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] tid, input bit push, input int extra, output int ac);
        int   i, n;
        exp_t e;
        @(negedge clk);
        bus.lsb_req_valid  = 1;
        bus.lsb_req_store  = st;
        bus.lsb_req_funct3 = f;
        bus.lsb_req_addr   = a;
        bus.lsb_req_data   = d;
        bus.lsb_req_id     = tid;
        i = 0;
        #1;
        while (!bus.lsb_req_ready && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("lsb_accept", i < 200, 1);
        ac = cyc;
        step();
        bus.lsb_req_valid = 0;
        n = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
        if (st) for (int k = 0; k < n; k++) mdl[18'(a + k)] = d[8*k +: 8];
        if (push) begin
            e.ic = 0;
            e.st = st;
            e.id = tid;
            e.data = st ? 0 : ld_exp(f, a);
            e.addr = 0;
            e.due = ac + n + (st ? 1 : 2) + extra;
            sbq.push_back(e);
        end
    endtask
    task automatic ic_op(input logic [31:0] a, input bit push, output int ac);
        int   i;
        exp_t e;
        @(negedge clk);
        bus.ic_req_valid = 1;
        bus.ic_req_addr  = a;
        i = 0;
        #1;
        while (!bus.ic_req_ready && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("ic_accept", i < 200, 1);
        ac = cyc;
        step();
        bus.ic_req_valid = 0;
        if (push) begin
            e.ic = 1;
            e.st = 0;
            e.id = 0;
            e.addr = a & ~32'(LB - 1);
            e.data = 0;
            for (int k = 0; k < LB; k++) e.data[8*k +: 8] = mdl[18'(e.addr + k)];
            e.due = ac + LB + 2;
            sbq.push_back(e);
        end
    endtask
    task automatic drain();
        int i = 0;
        while (sbq.size() != 0 && i < 200) begin
            step();
            i++;
        end
        check("drain", sbq.size(), 0);
        step();
    endtask
    always @(negedge clk) begin
        if (!rst_in && (bus.lsb_resp_valid || bus.ic_resp_valid)) begin
            if (sbq.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                me = sbq.pop_front();
                check("resp_kind", bus.ic_resp_valid, me.ic);
                check("resp_cycle", cyc, me.due);
                if (me.ic) begin
                    check("ic_addr", bus.ic_resp_addr, me.addr);
                    check("ic_line", bus.ic_resp_line, me.data);
                end else begin
                    check("lsb_store", bus.lsb_resp_store, me.st);
                    check("lsb_id", bus.lsb_resp_id, me.id);
                    check("lsb_data", bus.lsb_resp_data, me.data);
                end
            end
        end
    end
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < MW; i++) mdl[i] = pat(i);
        rst_in = 1; rdy_in = 1; flush = 0; io_full = 0;
        bus.lsb_req_valid = 0; bus.lsb_req_store = 0; bus.lsb_req_funct3 = 0;
        bus.lsb_req_addr = 0; bus.lsb_req_data = 0; bus.lsb_req_id = 0;
        bus.ic_req_valid = 0; bus.ic_req_addr = 0;
        repeat (3) step();
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_lsb_ready", bus.lsb_req_ready, 0);
        check("rst_ic_ready", bus.ic_req_ready, 0);
        check("rst_lsb_resp", {bus.lsb_resp_valid, bus.lsb_resp_store, bus.lsb_resp_id, bus.lsb_resp_data}, 0);
        check("rst_ic_resp", {bus.ic_resp_valid, bus.ic_resp_addr, bus.ic_resp_line}, 0);
        rst_in = 0;
        lsb_op(0, 3'b000, 32'h100, 0, 4'd5, 1, 0, acc);
        check("lb_addr", mem_a, 32'h100);
        check("lb_rd", mem_wr, 0);
        check("lb_model", ld_exp(3'b000, 32'h100), 32'hFFFFFF80);
        drain();
        lsb_op(0, 3'b100, 32'h100, 0, 4'd6, 1, 0, acc);
        drain();
        lsb_op(1, 3'b010, 32'h200, 32'h11223344, 4'd7, 1, 0, acc);
        for (int k = 0; k < 4; k++) begin
            check("sw_wr", mem_wr, 1);
            check("sw_addr", mem_a, 32'h200 + k);
            check("sw_dout", mem_dout, 8'h44 - 8'(k * 8'h11));
            step();
        end
        drain();
        lsb_op(0, 3'b010, 32'h200, 0, 4'd8, 1, 0, acc);
        drain();
        lsb_op(1, 3'b001, 32'h210, 32'h00008001, 4'd1, 1, 0, acc);
        drain();
        lsb_op(0, 3'b001, 32'h210, 0, 4'd2, 1, 0, acc);
        drain();
        lsb_op(0, 3'b101, 32'h210, 0, 4'd3, 1, 0, acc);
        drain();
        ic_op(32'h1008, 1, acc);
        check("ic_a_first", mem_a, 32'h1000);
        repeat (15) step();
        check("ic_a_last", mem_a, 32'h100F);
        drain();
        fork
            lsb_op(0, 3'b000, 32'h101, 0, 4'd9, 1, 0, acc);
            ic_op(32'h2004, 1, acc2);
        join
        check("arb_ic_after_resp", acc2, acc + 4);
        drain();
        io_full = 1;
        lsb_op(1, 3'b000, 32'h30000, 32'h000000A5, 4'd3, 1, 3, acc);
        check("io_stall0", mem_wr, 0);
        step();
        flush = 1;
        #1;
        check("io_stall1", mem_wr, 0);
        step();
        flush = 0;
        check("io_stall2", mem_wr, 0);
        step();
        io_full = 0;
        #1;
        check("io_wr", mem_wr, 1);
        check("io_addr", mem_a, 32'h30000);
        check("io_dout", mem_dout, 8'hA5);
        drain();
        io_full = 1;
        lsb_op(0, 3'b100, 32'h30000, 0, 4'd4, 1, 0, acc);
        drain();
        io_full = 0;
        lsb_op(0, 3'b010, 32'h100, 0, 4'd11, 0, 0, acc);
        step();
        flush = 1;
        step();
        flush = 0;
        #1;
        check("flush_idle_ready", bus.lsb_req_ready, 1);
        lsb_op(0, 3'b010, 32'h104, 0, 4'd12, 1, 0, acc2);
        check("flush_reaccept", acc2, acc + 3);
        drain();
        lsb_op(0, 3'b010, 32'h104, 0, 4'd13, 1, 2, acc);
        step();
        rdy_in = 0;
        #1;
        check("frz_addr", mem_a, 32'h104);
        step();
        check("frz_hold", mem_a, 32'h104);
        step();
        rdy_in = 1;
        #1;
        check("frz_resume", mem_a, 32'h105);
        drain();
        lsb_op(0, 3'b010, 32'hFFFFFFFE, 0, 4'd14, 1, 0, acc);
        check("wrap_a0", mem_a, 32'hFFFFFFFE);
        step();
        step();
        check("wrap_a2", mem_a, 32'h0);
        drain();
        for (int r = 0; r < 16; r++) begin
            if ($urandom_range(0, 1) == 1)
                lsb_op(1, 3'($urandom_range(0, 2)), 32'h400 + $urandom_range(0, 60), $urandom, 4'(r), 1, 0, acc);
            else
                lsb_op(0, lf[$urandom_range(0, 4)], 32'h400 + $urandom_range(0, 60), 0, 4'(r), 1, 0, acc);
            drain();
        end
        ic_op(32'h400, 1, acc);
        drain();
        ic_op(32'h3000, 0, acc);
        repeat (5) step();
        rst_in = 1;
        step();
        check("rst_fill_mem", {mem_a, mem_wr, mem_dout}, 0);
        check("rst_fill_ready", {bus.lsb_req_ready, bus.ic_req_ready}, 0);
        check("rst_fill_lsb", {bus.lsb_resp_valid, bus.lsb_resp_store, bus.lsb_resp_id, bus.lsb_resp_data}, 0);
        check("rst_fill_ic", {bus.ic_resp_valid, bus.ic_resp_addr, bus.ic_resp_line}, 0);
        rst_in = 0;
        lsb_op(0, 3'b100, 32'h100, 0, 4'd15, 1, 0, acc);
        drain();
        repeat (5) step();
        check("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
